sub2_result_buffer: RTL

SUB2_RESULT_BUFFER -- requirements
Module: sub2_result_buffer

---
 rtl/sub2_result_buffer.sv | 116 +++++++++++
 1 files changed

// File: rtl/sub2_result_buffer.sv
// rtl/sub2_result_buffer.sv - tag delay line and FWFT result FIFO behind the fixed-latency sub2 unit
// Optional build macro SUB2_RESULT_COUNT_EN adds the 16-bit popped-result counter output.
module sub2_result_buffer #(
    parameter int LATENCY = 5,
    parameter int DEPTH   = 8,
    parameter int TAGW    = 4
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            in_valid,
    input  logic [TAGW-1:0] in_tag,
    output logic            in_ready,
    input  logic [47:0]     sub_result,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [47:0]     out_data,
    output logic [TAGW-1:0] out_tag
`ifdef SUB2_RESULT_COUNT_EN
    ,
    output logic [15:0]     result_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(DEPTH + LATENCY + 1);

    logic [LATENCY-1:0] dl_valid;
    logic [TAGW-1:0]    dl_tag [LATENCY];
    logic [47:0]        mem_data [DEPTH];
    logic [TAGW-1:0]    mem_tag [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [CW-1:0]      count;
    logic [SW-1:0]      inflight;
    logic [SW-1:0]      occupancy;
    logic               issue;
    logic               wr_en;
    logic               pop;

    assign issue = in_valid & in_ready;
    assign wr_en = dl_valid[LATENCY-1];
    assign pop   = out_valid & out_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dl_valid <= '0;
        end else begin
            dl_valid[0] <= issue;
            for (int i = 1; i < LATENCY; i++) begin
                dl_valid[i] <= dl_valid[i-1];
            end
        end
    end

    // Tags only mean something alongside their valid bit, so they need no reset.
    always_ff @(posedge clock) begin
        dl_tag[0] <= in_tag;
        for (int i = 1; i < LATENCY; i++) begin
            dl_tag[i] <= dl_tag[i-1];
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_data[wr_ptr] <= sub_result;
            mem_tag[wr_ptr]  <= dl_tag[LATENCY-1];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        inflight = '0;
        for (int i = 0; i < LATENCY; i++) begin
            inflight = inflight + SW'(dl_valid[i]);
        end
    end

    // Every pair in the delay line already owns a FIFO slot, so writes can never overflow.
    assign occupancy = SW'(count) + inflight;
    assign in_ready  = reset_n & (occupancy < SW'(DEPTH));

    assign out_valid = (count != '0);
    assign out_data  = out_valid ? mem_data[rd_ptr] : '0;
    assign out_tag   = out_valid ? mem_tag[rd_ptr]  : '0;

`ifdef SUB2_RESULT_COUNT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            result_count <= '0;
        end else if (pop) begin
            result_count <= result_count + 16'd1;
        end
    end
`endif

endmodule
